// File: rtl/uart_rxdrain_pkg.sv
// Shared constants and state encoding for the UART receive-ring drain.
package uart_rxdrain_pkg;

    localparam int unsigned RING_LOG2      = 3;
    localparam logic [7:0]  TERM_BYTE_DFLT = 8'h0D;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } drain_state_e;

endpackage

// File: rtl/uart_rxdrain.sv
// Drains the UART receive ring in order onto a registered valid/ready byte stream,
// tracking occupancy from tail pointer advances and flagging overruns.
module uart_rxdrain
    import uart_rxdrain_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = RING_LOG2,
    parameter logic [7:0]  TERM_BYTE  = TERM_BYTE_DFLT
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [DEPTH_LOG2-1:0] tail_addr,
    input  logic [7:0]            rd_data,
    output logic [DEPTH_LOG2-1:0] rd_addr,
    input  logic                  flush,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   pending,
    output logic                  ovf,
    input  logic                  clr_ovf
);

    localparam logic [DEPTH_LOG2:0] PEND_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    drain_state_e            state_q, state_d;
    logic [DEPTH_LOG2-1:0]   head_q, head_d;
    logic [DEPTH_LOG2-1:0]   tail_q, tail_d;
    logic [DEPTH_LOG2:0]     pending_q, pending_d;
    logic [7:0]              data_q, data_d;
    logic                    last_q, last_d;
    logic                    ovf_q, ovf_d;
    logic                    arr, fetch, overrun;

    always_comb begin
        arr       = (tail_addr != tail_q);
        fetch     = (pending_q != '0) && ((state_q == S_EMPTY) || out_ready);
        overrun   = arr && !fetch && (pending_q == PEND_FULL);
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        pending_d = pending_q;
        data_d    = data_q;
        last_d    = last_q;
        ovf_d     = ovf_q;

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        if (flush) begin
            head_d    = tail_addr;
            tail_d    = tail_addr;
            pending_d = '0;
            state_d   = S_EMPTY;
        end else begin
            tail_d = tail_addr;
            if (fetch) begin
                data_d  = rd_data;
                last_d  = (rd_data == TERM_BYTE);
                head_d  = head_q + 1'b1;
                state_d = S_FULL;
            end else if ((state_q == S_FULL) && out_ready) begin
                state_d = S_EMPTY;
            end

            if (arr && !fetch && !overrun) begin
                pending_d = pending_q + 1'b1;
            end else if (fetch && !arr) begin
                pending_d = pending_q - 1'b1;
            end

            // Ring full and nothing drained: the oldest unfetched slot is being
            // overwritten, so skip past it; set beats a same-cycle clear.
            if (overrun) begin
                head_d = head_q + 1'b1;
                ovf_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            pending_q <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rd_addr   = head_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_valid = (state_q == S_FULL);
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_uart_rxdrain.sv
// Directed self-checking bench for uart_rxdrain with a behavioural receive ring.
module tb_uart_rxdrain;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [2:0] tail_addr = 3'd0;
    logic [7:0] rd_data;
    logic [2:0] rd_addr;
    logic       flush = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] pending;
    logic       ovf;
    logic       clr_ovf = 1'b0;

    logic [7:0] mem [8];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    uart_rxdrain dut (
        .clk       (clk),
        .nrst      (nrst),
        .tail_addr (tail_addr),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .flush     (flush),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Emulates the receive buffer: write at the tail and advance it together.
    task automatic push(input logic [7:0] b);
        mem[tail_addr] = b;
        tail_addr = tail_addr + 3'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        #12;
        nrst = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_last", 32'(out_last), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_head", 32'(rd_addr), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);

        // Single byte, two-cycle latency
        out_ready = 1'b1;
        push(8'h41);
        tick();
        chk("one_pend1", 32'(pending), 32'h1);
        chk("one_valid_early", 32'(out_valid), 32'h0);
        tick();
        chk("one_valid", 32'(out_valid), 32'h1);
        chk("one_data", 32'(out_data), 32'h41);
        chk("one_last", 32'(out_last), 32'h0);
        chk("one_pend0", 32'(pending), 32'h0);
        chk("one_head", 32'(rd_addr), 32'h1);
        tick();
        chk("one_drained", 32'(out_valid), 32'h0);

        // Backpressure
        out_ready = 1'b0;
        push(8'h61); tick();
        push(8'h62); tick();
        push(8'h0D); tick();
        for (int i = 0; i < 20; i++) tick();
        chk("bp_hold_data", 32'(out_data), 32'h61);
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        chk("bp_pending", 32'(pending), 32'h2);
        out_ready = 1'b1;
        tick();
        chk("bp_b2_data", 32'(out_data), 32'h62);
        chk("bp_b2_last", 32'(out_last), 32'h0);
        tick();
        chk("bp_b3_data", 32'(out_data), 32'h0D);
        chk("bp_b3_last", 32'(out_last), 32'h1);
        chk("bp_b3_valid", 32'(out_valid), 32'h1);
        tick();
        chk("bp_done", 32'(out_valid), 32'h0);

        // Overrun: head=tail=4, bytes 8'h11..8'h1A
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            push(8'(8'h10 + k));
            tick();
        end
        chk("ovr_pend8", 32'(pending), 32'h8);
        chk("ovr_no_ovf_yet", 32'(ovf), 32'h0);
        push(8'h1A);
        tick();
        chk("ovr_ovf", 32'(ovf), 32'h1);
        chk("ovr_pend_stay", 32'(pending), 32'h8);
        chk("ovr_head", 32'(rd_addr), 32'h6);
        chk("ovr_first_kept", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        for (int k = 3; k <= 10; k++) begin
            tick();
            chk("ovr_drain", 32'(out_data), 32'(8'h10 + k));
        end
        tick();
        out_ready = 1'b0;
        chk("ovr_drain_end", 32'(out_valid), 32'h0);
        chk("ovr_sticky", 32'(ovf), 32'h1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovr_clr", 32'(ovf), 32'h0);

        // Wrap: 20 streamed bytes, one per cycle
        out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) push(8'(8'hA0 + i));
            tick();
            if (i >= 1) begin
                chk("wrap_valid", 32'(out_valid), 32'h1);
                chk("wrap_data", 32'(out_data), 32'(8'hA0 + i - 1));
            end
        end
        tick();
        chk("wrap_end", 32'(out_valid), 32'h0);

        // Simultaneous arrival and fetch with a full ring
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            push(8'(8'hC0 + k));
            tick();
        end
        chk("sim_pend8", 32'(pending), 32'h8);
        out_ready = 1'b1;
        push(8'hC9);
        tick();
        out_ready = 1'b0;
        chk("sim_pend_stay", 32'(pending), 32'h8);
        chk("sim_no_ovf", 32'(ovf), 32'h0);
        chk("sim_valid", 32'(out_valid), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sim_flush_pend", 32'(pending), 32'h0);

        // Flush with pending=5 and a held byte
        for (int k = 0; k < 6; k++) begin
            push(8'(8'hE0 + k));
            tick();
        end
        chk("fl_pend5", 32'(pending), 32'h5);
        chk("fl_valid_before", 32'(out_valid), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'h0);
        chk("fl_pend", 32'(pending), 32'h0);
        chk("fl_head", 32'(rd_addr), 32'(tail_addr));
        tick();
        chk("fl_stays_empty", 32'(out_valid), 32'h0);

        // Async reset mid-burst, no clock edge
        push(8'h55); tick();
        push(8'h56); tick();
        push(8'h57); tick();
        chk("ar_busy", 32'(out_valid), 32'h1);
        #2;
        nrst = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_data", 32'(out_data), 32'h0);
        chk("ar_last", 32'(out_last), 32'h0);
        chk("ar_pending", 32'(pending), 32'h0);
        chk("ar_head", 32'(rd_addr), 32'h0);
        chk("ar_ovf", 32'(ovf), 32'h0);
        tail_addr = 3'd0;
        tick();
        nrst = 1'b1;
        tick();
        chk("ar_after", 32'(pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
